// File: rtl/loom_axil_pkg.sv
// Shared constants, FSM state encoding and helpers for the loom AXI-Lite register bridge.
package loom_axil_pkg;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    WR_RESP,
    RD_RESP
  } state_t;

  // Saturating increment for the 16-bit watchdog expiry counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/loom_axil_hold_reg.sv
// One-entry valid/ready capture register; holds a beat until the owner clears it.
module loom_axil_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             valid,
  input  logic [WIDTH-1:0] payload,
  input  logic             clear,
  output logic             ready,
  output logic             held,
  output logic [WIDTH-1:0] data
);

  logic             held_reg;
  logic [WIDTH-1:0] data_reg;

  assign ready = enable && !held_reg;
  assign held  = held_reg;
  assign data  = data_reg;

  // clear only happens in an issue state and capture only in IDLE, so they never collide.
  always_ff @(posedge clk) begin
    if (srst) begin
      held_reg <= 1'b0;
      data_reg <= '0;
    end else if (clear) begin
      held_reg <= 1'b0;
    end else if (valid && ready) begin
      held_reg <= 1'b1;
      data_reg <= payload;
    end
  end

endmodule

// File: rtl/loom_axil_reg_slave.sv
// AXI-Lite subordinate bridging to a single-outstanding register bus, with
// round-robin read/write arbitration and a watchdog that turns a lost ack into SLVERR.
module loom_axil_reg_slave
  import loom_axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr_i,
  input  logic                    s_axil_awvalid_i,
  output logic                    s_axil_awready_o,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb_i,
  input  logic                    s_axil_wvalid_i,
  output logic                    s_axil_wready_o,
  output logic [1:0]              s_axil_bresp_o,
  output logic                    s_axil_bvalid_o,
  input  logic                    s_axil_bready_i,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr_i,
  input  logic                    s_axil_arvalid_i,
  output logic                    s_axil_arready_o,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata_o,
  output logic [1:0]              s_axil_rresp_o,
  output logic                    s_axil_rvalid_o,
  input  logic                    s_axil_rready_i,
  output logic                    reg_req_o,
  output logic                    reg_we_o,
  output logic [ADDR_WIDTH-1:0]   reg_addr_o,
  output logic [DATA_WIDTH-1:0]   reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
  input  logic                    reg_ack_i,
  input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
  input  logic                    reg_err_i,
  output logic [15:0]             timeout_cnt_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
  localparam bit WD_EN      = (TIMEOUT_CYCLES != 0);
  localparam int WD_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                  state_reg;
  logic                    live_reg;
  logic                    rr_last_write_reg;
  logic [WD_W-1:0]         wd_cnt_reg;
  logic [15:0]             timeout_cnt_reg;
  logic                    req_reg;
  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_WIDTH-1:0]   wstrb_reg;
  logic                    bvalid_reg;
  logic [1:0]              bresp_reg;
  logic                    rvalid_reg;
  logic [1:0]              rresp_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic                    accept_en;
  logic                    aw_held, w_held, ar_held;
  logic [ADDR_WIDTH-1:0]   aw_data, ar_data;
  logic [W_WIDTH-1:0]      w_data;
  logic                    wr_clear, rd_clear;
  logic                    wr_elig, rd_elig, grant_write;
  logic                    issue_state, wd_expire, issue_done;
  logic [1:0]              issue_resp;

  // live_reg keeps the readies low for the first cycle out of reset.
  assign accept_en = live_reg && (state_reg == IDLE);

  loom_axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk     (clk_i),
    .srst    (rst_i),
    .enable  (accept_en),
    .valid   (s_axil_awvalid_i),
    .payload (s_axil_awaddr_i),
    .clear   (wr_clear),
    .ready   (s_axil_awready_o),
    .held    (aw_held),
    .data    (aw_data)
  );

  loom_axil_hold_reg #(.WIDTH(W_WIDTH)) u_w_hold (
    .clk     (clk_i),
    .srst    (rst_i),
    .enable  (accept_en),
    .valid   (s_axil_wvalid_i),
    .payload ({s_axil_wdata_i, s_axil_wstrb_i}),
    .clear   (wr_clear),
    .ready   (s_axil_wready_o),
    .held    (w_held),
    .data    (w_data)
  );

  loom_axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
    .clk     (clk_i),
    .srst    (rst_i),
    .enable  (accept_en),
    .valid   (s_axil_arvalid_i),
    .payload (s_axil_araddr_i),
    .clear   (rd_clear),
    .ready   (s_axil_arready_o),
    .held    (ar_held),
    .data    (ar_data)
  );

  assign wr_elig     = aw_held && w_held;
  assign rd_elig     = ar_held;
  assign grant_write = wr_elig && (!rd_elig || !rr_last_write_reg);

  assign issue_state = (state_reg == WR_ISSUE) || (state_reg == RD_ISSUE);
  assign wd_expire   = WD_EN && (wd_cnt_reg == WD_LAST);
  assign issue_done  = issue_state && (reg_ack_i || wd_expire);
  // An ack in the expiry cycle takes precedence over the watchdog.
  assign issue_resp  = (reg_ack_i && !reg_err_i) ? RESP_OKAY : RESP_SLVERR;

  assign wr_clear = issue_done && (state_reg == WR_ISSUE);
  assign rd_clear = issue_done && (state_reg == RD_ISSUE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      live_reg          <= 1'b0;
      rr_last_write_reg <= 1'b1;
      wd_cnt_reg        <= '0;
      timeout_cnt_reg   <= '0;
      req_reg           <= 1'b0;
      we_reg            <= 1'b0;
      addr_reg          <= '0;
      wdata_reg         <= '0;
      wstrb_reg         <= '0;
      bvalid_reg        <= 1'b0;
      bresp_reg         <= RESP_OKAY;
      rvalid_reg        <= 1'b0;
      rresp_reg         <= RESP_OKAY;
      rdata_reg         <= '0;
    end else begin
      live_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          wd_cnt_reg <= '0;
          // Round-robin pointer only moves when both sides actually contended.
          if (grant_write) begin
            state_reg <= WR_ISSUE;
            req_reg   <= 1'b1;
            we_reg    <= 1'b1;
            addr_reg  <= {aw_data[ADDR_WIDTH-1:2], 2'b00};
            wdata_reg <= w_data[W_WIDTH-1:STRB_WIDTH];
            wstrb_reg <= w_data[STRB_WIDTH-1:0];
            if (rd_elig) rr_last_write_reg <= 1'b1;
          end else if (rd_elig) begin
            state_reg <= RD_ISSUE;
            req_reg   <= 1'b1;
            we_reg    <= 1'b0;
            addr_reg  <= {ar_data[ADDR_WIDTH-1:2], 2'b00};
            wdata_reg <= '0;
            wstrb_reg <= '0;
            if (wr_elig) rr_last_write_reg <= 1'b0;
          end
        end
        WR_ISSUE, RD_ISSUE: begin
          wd_cnt_reg <= wd_cnt_reg + 1'b1;
          if (issue_done) begin
            req_reg <= 1'b0;
            if (!reg_ack_i) timeout_cnt_reg <= sat_inc16(timeout_cnt_reg);
            if (state_reg == WR_ISSUE) begin
              bvalid_reg <= 1'b1;
              bresp_reg  <= issue_resp;
              state_reg  <= WR_RESP;
            end else begin
              rvalid_reg <= 1'b1;
              rresp_reg  <= issue_resp;
              rdata_reg  <= reg_ack_i ? reg_rdata_i : TIMEOUT_RDATA;
              state_reg  <= RD_RESP;
            end
          end
        end
        WR_RESP: begin
          if (s_axil_bready_i) begin
            bvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        RD_RESP: begin
          if (s_axil_rready_i) begin
            rvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign reg_req_o       = req_reg;
  assign reg_we_o        = we_reg;
  assign reg_addr_o      = addr_reg;
  assign reg_wdata_o     = wdata_reg;
  assign reg_wstrb_o     = wstrb_reg;
  assign s_axil_bvalid_o = bvalid_reg;
  assign s_axil_bresp_o  = bresp_reg;
  assign s_axil_rvalid_o = rvalid_reg;
  assign s_axil_rresp_o  = rresp_reg;
  assign s_axil_rdata_o  = rdata_reg;
  assign timeout_cnt_o   = timeout_cnt_reg;

endmodule

// File: tb/tb_loom_axil_reg_slave.sv
// Directed + randomized bench for loom_axil_reg_slave with a register-target memory model.
module tb_loom_axil_reg_slave;

  localparam int AW = 20;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [AW-1:0] araddr;
  logic          arvalid, arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;
  logic          req, we;
  logic [AW-1:0] addr;
  logic [31:0]   reg_wdata;
  logic [3:0]    reg_wstrb;
  logic          ack;
  logic [31:0]   reg_rdata;
  logic          reg_err;
  logic [15:0]   tcnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [int];

  always #5 clk = ~clk;

  loom_axil_reg_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
    .reg_req_o(req), .reg_we_o(we), .reg_addr_o(addr), .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb),
    .reg_ack_i(ack), .reg_rdata_i(reg_rdata), .reg_err_i(reg_err), .timeout_cnt_o(tcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
             req, we, addr, reg_wdata, reg_wstrb, tcnt};
  endfunction

  function automatic logic [AW-1:0] word(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  // Offer any of AW/W/AR after per-channel delays; returns once every offered beat was accepted.
  task automatic send(input bit do_aw, input logic [AW-1:0] awa, input int aw_dly,
                      input bit do_w, input logic [31:0] wd, input logic [3:0] ws, input int w_dly,
                      input bit do_ar, input logic [AW-1:0] ara, input int ar_dly,
                      output bit req_seen);
    bit aw_done, w_done, ar_done, f_aw, f_w, f_ar;
    aw_done = !do_aw; w_done = !do_w; ar_done = !do_ar;
    req_seen = 1'b0;
    awaddr = awa; wdata = wd; wstrb = ws; araddr = ara;
    for (int k = 0; k < 60 && !(aw_done && w_done && ar_done); k++) begin
      awvalid = !aw_done && (k >= aw_dly);
      wvalid  = !w_done && (k >= w_dly);
      arvalid = !ar_done && (k >= ar_dly);
      f_aw = awvalid && awready;
      f_w  = wvalid && wready;
      f_ar = arvalid && arready;
      if (req) req_seen = 1'b1;
      tick();
      if (f_aw) aw_done = 1'b1;
      if (f_w)  w_done  = 1'b1;
      if (f_ar) ar_done = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("send_accepted", {aw_done, w_done, ar_done}, 3'b111);
  endtask

  // Act as the register target for one request and complete the AXI response.
  task automatic serve(input bit exp_we, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input int ack_dly, input bit err,
                       input logic [31:0] rd_val, input int rdy_dly);
    int n;
    logic [1:0] exp_resp;
    n = 0;
    while (!req && n < 50) begin
      tick();
      n++;
    end
    chk("req_latency", n, 1);
    chk("req_we", we, exp_we);
    chk("req_addr", addr, word(a));
    chk("req_wstrb", reg_wstrb, exp_we ? ws : 4'h0);
    if (exp_we) chk("req_wdata", reg_wdata, wd);
    for (int k = 0; k < ack_dly; k++) tick();
    chk("req_hold", req, 1'b1);
    ack = 1'b1; reg_err = err; reg_rdata = rd_val;
    tick();
    ack = 1'b0; reg_err = 1'b0; reg_rdata = 32'h0;
    exp_resp = err ? 2'b10 : 2'b00;
    chk("req_drop", req, 1'b0);
    for (int k = 0; k <= rdy_dly; k++) begin
      if (exp_we) begin
        chk("bvalid", bvalid, 1'b1);
        chk("bresp", bresp, exp_resp);
      end else begin
        chk("rvalid", rvalid, 1'b1);
        chk("rresp", rresp, exp_resp);
        chk("rdata", rdata, rd_val);
      end
      if (k < rdy_dly) tick();
    end
    if (exp_we) bready = 1'b1; else rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("resp_done", {bvalid, rvalid}, 2'b00);
    if (exp_we && !err) begin
      logic [31:0] cur;
      cur = mem.exists(int'(word(a))) ? mem[int'(word(a))] : 32'h0;
      for (int b = 0; b < 4; b++) if (ws[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
      mem[int'(word(a))] = cur;
    end
  endtask

  // Read that the target never acks; expect the watchdog response.
  task automatic serve_timeout(input logic [AW-1:0] a, input logic [15:0] exp_cnt);
    int n, hi;
    n = 0;
    while (!req && n < 50) begin
      tick();
      n++;
    end
    chk("to_addr", addr, word(a));
    hi = 0;
    while (req && hi < 40) begin
      tick();
      hi++;
    end
    chk("to_req_cycles", hi, TO);
    chk("to_rvalid", rvalid, 1'b1);
    chk("to_rresp", rresp, 2'b10);
    chk("to_rdata", rdata, 32'hDEADBEEF);
    chk("to_count", tcnt, exp_cnt);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("to_done", rvalid, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", any_out(), 1'b0);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bit seen, bad;
    logic [15:0] exp_tcnt;
    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;

    do_reset();
    chk("ready_after_reset", {awready, wready, arready}, 3'b111);

    // Write with AW and W together, ack two cycles after req.
    send(1, 20'h00104, 0, 1, 32'hCAFEF00D, 4'hF, 0, 0, '0, 0, seen);
    serve(1, 20'h00104, 32'hCAFEF00D, 4'hF, 2, 0, 32'h0, 0);

    // W first, AW five cycles later: no request until AW lands.
    send(1, 20'h00008, 5, 1, 32'h0000BEEF, 4'h3, 0, 0, '0, 0, seen);
    chk("w_only_no_req", seen, 1'b0);
    serve(1, 20'h00008, 32'h0000BEEF, 4'h3, 0, 0, 32'h0, 0);

    // Unaligned read acked with error.
    send(0, '0, 0, 0, '0, '0, 0, 1, 20'h00013, 0, seen);
    serve(0, 20'h00013, '0, '0, 1, 1, 32'h12345678, 0);

    // Stray acks while idle must be ignored.
    ack = 1'b1;
    tick(); tick(); tick();
    ack = 1'b0;
    chk("idle_ack_ignored", {bvalid, rvalid, req}, 3'b000);

    // Contention right after reset: read first, then write; next contention write first.
    do_reset();
    send(1, 20'h00200, 0, 1, 32'hA5A5A5A5, 4'hF, 0, 1, 20'h00300, 0, seen);
    serve(0, 20'h00300, '0, '0, 0, 0, 32'h11112222, 0);
    serve(1, 20'h00200, 32'hA5A5A5A5, 4'hF, 0, 0, 32'h0, 0);
    send(1, 20'h00204, 0, 1, 32'h5A5A5A5A, 4'hC, 0, 1, 20'h00304, 0, seen);
    serve(1, 20'h00204, 32'h5A5A5A5A, 4'hC, 0, 0, 32'h0, 0);
    serve(0, 20'h00304, '0, '0, 0, 0, 32'h33334444, 0);

    // Watchdog expiry, then an ack landing exactly in the expiry cycle.
    send(0, '0, 0, 0, '0, '0, 0, 1, 20'h00040, 0, seen);
    serve_timeout(20'h00040, 16'd1);
    send(0, '0, 0, 0, '0, '0, 0, 1, 20'h00044, 0, seen);
    serve(0, 20'h00044, '0, '0, TO - 1, 0, 32'h0BADF00D, 0);
    chk("expiry_ack_count", tcnt, 16'd1);

    // Response backpressure: payloads stay put for ten cycles.
    send(1, 20'h00050, 0, 1, 32'h01020304, 4'h9, 0, 0, '0, 0, seen);
    serve(1, 20'h00050, 32'h01020304, 4'h9, 0, 1, 32'h0, 10);
    send(0, '0, 0, 0, '0, '0, 0, 1, 20'h00054, 0, seen);
    serve(0, 20'h00054, '0, '0, 0, 0, 32'h76543210, 10);

    // Reset while a read is outstanding: everything clears, no response follows.
    send(0, '0, 0, 0, '0, '0, 0, 1, 20'h00080, 0, seen);
    for (int k = 0; k < 10 && !req; k++) tick();
    chk("pre_reset_req", req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_outputs", any_out(), 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rvalid || req) bad = 1'b1;
    end
    chk("no_resp_after_reset", bad, 1'b0);

    // Randomized traffic against the memory model.
    exp_tcnt = 16'd0;
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      logic [31:0]   d, rv;
      logic [3:0]    s;
      bit            err, is_wr;
      a     = AW'($urandom_range(0, 255));
      d     = $urandom;
      s     = 4'($urandom_range(1, 15));
      err   = ($urandom_range(0, 7) == 0);
      is_wr = $urandom_range(0, 1) == 1;
      if (is_wr) begin
        send(1, a, $urandom_range(0, 3), 1, d, s, $urandom_range(0, 3), 0, '0, 0, seen);
        serve(1, a, d, s, $urandom_range(0, 5), err, 32'h0, $urandom_range(0, 3));
      end else if ($urandom_range(0, 9) == 0) begin
        send(0, '0, 0, 0, '0, '0, 0, 1, a, $urandom_range(0, 2), seen);
        exp_tcnt = exp_tcnt + 16'd1;
        serve_timeout(a, exp_tcnt);
      end else begin
        rv = mem.exists(int'(word(a))) ? mem[int'(word(a))] : 32'h0;
        send(0, '0, 0, 0, '0, '0, 0, 1, a, $urandom_range(0, 2), seen);
        serve(0, a, '0, '0, $urandom_range(0, 5), err, rv, $urandom_range(0, 3));
      end
      $display("txn %0d %s addr=0x%05h tcnt=%0d", t, is_wr ? "WR" : "RD", a, tcnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
